// File: rtl/valu_pkg.sv
// Shared types and constants for the vector ALU sequencer: lane geometry, vector type,
// sequencer states, opcodes and flag bit positions.
package valu_pkg;

  localparam int unsigned N     = 18;
  localparam int unsigned V     = 3;
  localparam int unsigned R     = 8;
  localparam int unsigned RegAw = $clog2(R);

  typedef logic [V-1:0][N-1:0] vec_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWb
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_RSUM = 4'b0101;

  // alu_flags is packed {overflow, carry, zero, negative}
  localparam int unsigned FLG_N = 0;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 3;

endpackage

// File: rtl/valu_sequencer_if.sv
// Command handshake plus operand/result bus between the sequencer and the vector ALU.
// The slave modport is the sequencer; master is the command source and ALU side.
interface valu_sequencer_if;
  import valu_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [RegAw-1:0] cmd_srca;
  logic [RegAw-1:0] cmd_srcb;
  logic [RegAw-1:0] cmd_dst;

  vec_t             alu_a;
  vec_t             alu_b;
  logic [3:0]       alu_op;
  vec_t             alu_result;
  logic [3:0]       alu_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_dst,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_srca, cmd_srcb, cmd_dst,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_flags
  );

endinterface

// File: rtl/valu_regfile.sv
// Vector register file: R entries of vec_t, asynchronous clear, one synchronous write port
// and three combinational read ports (operand A, operand B, host).
module valu_regfile
  import valu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [RegAw-1:0] waddr_i,
  input  vec_t             wdata_i,
  input  logic [RegAw-1:0] raddr_a_i,
  input  logic [RegAw-1:0] raddr_b_i,
  input  logic [RegAw-1:0] raddr_h_i,
  output vec_t             rdata_a_o,
  output vec_t             rdata_b_o,
  output vec_t             rdata_h_o
);

  vec_t mem_q [R];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < R; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
  assign rdata_h_o = mem_q[raddr_h_i];

endmodule

// File: rtl/valu_sequencer.sv
// Vector ALU initiator: accepts a command, reads two source vectors, presents them to the
// external ALU, captures result and flags, and writes the result back (4 cycles per command).
module valu_sequencer
  import valu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  valu_sequencer_if.slave  bus,
  input  logic             host_wr_en,
  input  logic [RegAw-1:0] host_addr,
  input  vec_t             host_wdata,
  output vec_t             host_rdata,
  output logic             done,
  output logic [3:0]       flags_q,
  output logic [15:0]      op_count
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, alu_op_q, flg_q, last_flags_q;
  logic [RegAw-1:0] srca_q, srcb_q, dst_q;
  vec_t             opa_q, opb_q, res_q;
  vec_t             rd_a, rd_b;
  logic [15:0]      op_count_q;
  logic             accept;
  logic             rf_we;
  logic [RegAw-1:0] rf_waddr;
  vec_t             rf_wdata;

  // A host write in the same cycle takes priority over a new command.
  assign bus.cmd_ready = (state_q == StIdle) && !host_wr_en;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Host writes are only honoured in idle; writeback owns the port in StWb.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = host_addr;
    rf_wdata = host_wdata;
    if (state_q == StWb) begin
      rf_we    = 1'b1;
      rf_waddr = dst_q;
      rf_wdata = res_q;
    end else if ((state_q == StIdle) && host_wr_en) begin
      rf_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      srca_q       <= '0;
      srcb_q       <= '0;
      dst_q        <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      alu_op_q     <= '0;
      res_q        <= '0;
      flg_q        <= '0;
      last_flags_q <= '0;
      op_count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= bus.cmd_op;
        srca_q <= bus.cmd_srca;
        srcb_q <= bus.cmd_srcb;
        dst_q  <= bus.cmd_dst;
      end
      // Operands and opcode change together on entry to StExec and hold afterwards.
      if (state_q == StRead) begin
        opa_q    <= rd_a;
        opb_q    <= rd_b;
        alu_op_q <= op_q;
      end
      if (state_q == StExec) begin
        res_q <= bus.alu_result;
        flg_q <= bus.alu_flags;
      end
      if (state_q == StWb) begin
        last_flags_q <= flg_q;
        op_count_q   <= op_count_q + 16'd1;
      end
    end
  end

  assign bus.alu_a  = opa_q;
  assign bus.alu_b  = opb_q;
  assign bus.alu_op = alu_op_q;
  assign done       = (state_q == StWb);
  assign flags_q    = last_flags_q;
  assign op_count   = op_count_q;

  valu_regfile u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (srca_q),
    .raddr_b_i (srcb_q),
    .raddr_h_i (host_addr),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b),
    .rdata_h_o (host_rdata)
  );

endmodule

// File: tb/tb_valu_sequencer.sv
// Self-checking bench for valu_sequencer; acts as the external vector ALU and keeps a
// register-file/counter reference model of the expected architectural state.
module tb_valu_sequencer;
  import valu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_wr_en;
  logic [2:0]  host_addr;
  vec_t        host_wdata;
  vec_t        host_rdata;
  logic        done;
  logic [3:0]  flags_q;
  logic [15:0] op_count;

  int          n_tests = 0;
  int          n_fail = 0;
  int unsigned done_cnt = 0;
  int unsigned exp_done = 0;
  int unsigned cyc = 0;
  int unsigned last_hs = 0;

  vec_t        ref_rf [R];
  logic [3:0]  ref_flags;
  logic [15:0] ref_count;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  valu_sequencer_if bus ();

  valu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .host_wr_en (host_wr_en),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .done       (done),
    .flags_q    (flags_q),
    .op_count   (op_count)
  );

  function automatic vec_t alu_res(input logic [3:0] op, input vec_t a, input vec_t b);
    vec_t r;
    r = '0;
    case (op)
      OP_ADD:  for (int i = 0; i < V; i++) r[i] = a[i] + b[i];
      OP_SUB:  for (int i = 0; i < V; i++) r[i] = a[i] - b[i];
      OP_RSUM: r[0] = a[0] + a[1] + a[2];
      default: for (int i = 0; i < V; i++) r[i] = a[i] ^ b[i];
    endcase
    return r;
  endfunction

  function automatic logic [3:0] alu_flg(input logic [3:0] op, input vec_t a, input vec_t b);
    vec_t       r;
    logic [N:0] w;
    logic [3:0] f;
    r = alu_res(op, a, b);
    f = '0;
    f[FLG_Z] = (r[0] == '0);
    f[FLG_N] = r[0][N-1];
    if (op == OP_ADD) begin
      w = {1'b0, a[0]} + {1'b0, b[0]};
      f[FLG_C] = w[N];
      f[FLG_V] = (a[0][N-1] == b[0][N-1]) && (r[0][N-1] != a[0][N-1]);
    end else if (op == OP_SUB) begin
      f[FLG_C] = (a[0] < b[0]);
      f[FLG_V] = (a[0][N-1] != b[0][N-1]) && (r[0][N-1] != a[0][N-1]);
    end
    return f;
  endfunction

  assign bus.alu_result = alu_res(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_flags  = alu_flg(bus.alu_op, bus.alu_a, bus.alu_b);

  function automatic vec_t mk(input int unsigned l2, input int unsigned l1,
                              input int unsigned l0);
    vec_t v;
    v[2] = N'(l2);
    v[1] = N'(l1);
    v[0] = N'(l0);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[V*N-1:0];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < R; i++) ref_rf[i] = '0;
    ref_flags = '0;
    ref_count = '0;
  endtask

  task automatic read_reg(input int a, output vec_t d);
    host_addr = 3'(a);
    #1;
    d = host_rdata;
  endtask

  // Called from a negedge while idle; returns at the following negedge.
  task automatic host_write(input int a, input vec_t d);
    host_wr_en = 1'b1;
    host_addr  = 3'(a);
    host_wdata = d;
    @(negedge clk);
    host_wr_en = 1'b0;
    ref_rf[a]  = d;
  endtask

  // Issues one command, checks handshake and done latency, returns in the next idle cycle.
  task automatic run_cmd(input logic [3:0] op, input int a, input int b, input int d);
    vec_t       exp_res;
    logic [3:0] exp_flg;
    int         waitc;
    int         lat;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_srca  = 3'(a);
    bus.cmd_srcb  = 3'(b);
    bus.cmd_dst   = 3'(d);
    #1;
    waitc = 0;
    while (bus.cmd_ready !== 1'b1 && waitc < 16) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready,
               waitc);
      bus.cmd_valid = 1'b0;
      return;
    end
    last_hs = cyc;
    exp_res = alu_res(op, ref_rf[a], ref_rf[b]);
    exp_flg = alu_flg(op, ref_rf[a], ref_rf[b]);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL done_latency: done seen at T+%0d, required T+3", lat);
    end
    @(negedge clk);
    ref_rf[d] = exp_res;
    ref_flags = exp_flg;
    ref_count = ref_count + 16'd1;
    exp_done++;
  endtask

  task automatic test_reset();
    vec_t d;
    #1;
    n_tests++;
    if (done !== 1'b0 || op_count !== 16'd0 || flags_q !== 4'd0 || bus.cmd_ready !== 1'b1 ||
        bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_op !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: done=%b cnt=%h flags=%h rdy=%b a=%h b=%h op=%h, required 0..1..0",
               done, op_count, flags_q, bus.cmd_ready, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    // Abort an ADD in the middle of its execute cycle.
    host_write(1, mk(3, 2, 1));
    host_write(2, mk(30, 20, 10));
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_srca  = 3'd1;
    bus.cmd_srcb  = 3'd2;
    bus.cmd_dst   = 3'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", bus.cmd_ready);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (done_cnt !== exp_done || op_count !== 16'd0 || bus.alu_a !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: done_cnt=%0d cnt=%h alu_a=%h, required %0d 0 0", done_cnt,
               op_count, bus.alu_a, exp_done);
    end
    for (int i = 0; i < R; i++) begin
      read_reg(i, d);
      n_tests++;
      if (d !== '0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, required 0", i, d);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_host_rw();
    vec_t old_v, new_v, d;
    host_write(0, rand_vec());
    old_v = ref_rf[0];
    new_v = rand_vec();
    host_wr_en = 1'b1;
    host_addr  = 3'd0;
    host_wdata = new_v;
    #1;
    n_tests++;
    if (host_rdata !== old_v) begin
      n_fail++;
      $display("FAIL host_same_cycle_read: got %h, required %h", host_rdata, old_v);
    end
    @(negedge clk);
    host_wr_en = 1'b0;
    ref_rf[0] = new_v;
    read_reg(0, d);
    n_tests++;
    if (d !== new_v) begin
      n_fail++;
      $display("FAIL host_write: got %h, required %h", d, new_v);
    end
  endtask

  task automatic test_add();
    vec_t d;
    host_write(1, mk(3, 2, 1));
    host_write(2, mk(30, 20, 10));
    run_cmd(OP_ADD, 1, 2, 3);
    read_reg(3, d);
    n_tests++;
    if (d !== mk(33, 22, 11) || flags_q[FLG_Z] !== 1'b0 || op_count !== 16'd1) begin
      n_fail++;
      $display("FAIL add: r3=%h z=%b cnt=%h, required %h 0 1", d, flags_q[FLG_Z], op_count,
               mk(33, 22, 11));
    end
  endtask

  task automatic test_rsum();
    vec_t d;
    host_write(1, mk(5, 7, 9));
    run_cmd(OP_RSUM, 1, 0, 4);
    read_reg(4, d);
    n_tests++;
    if (d !== mk(0, 0, 21)) begin
      n_fail++;
      $display("FAIL rsum: r4=%h, required %h", d, mk(0, 0, 21));
    end
    host_write(1, mk(18'h3FFFF, 1, 0));
    run_cmd(OP_RSUM, 1, 0, 4);
    read_reg(4, d);
    n_tests++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL rsum_wrap: r4=%h, required 0", d);
    end
  endtask

  task automatic test_back_to_back();
    vec_t        d;
    int unsigned h1;
    host_write(1, mk(1, 1, 1));
    run_cmd(OP_ADD, 1, 1, 1);
    h1 = last_hs;
    run_cmd(OP_ADD, 1, 1, 1);
    n_tests++;
    if (last_hs - h1 != 4) begin
      n_fail++;
      $display("FAIL b2b_spacing: gap %0d cycles, required 4", last_hs - h1);
    end
    read_reg(1, d);
    n_tests++;
    if (d !== mk(4, 4, 4)) begin
      n_fail++;
      $display("FAIL alias: r1=%h, required %h", d, mk(4, 4, 4));
    end
  endtask

  task automatic test_busy();
    vec_t exp7, d;
    int   accepted;
    host_write(5, rand_vec());
    host_write(2, rand_vec());
    host_write(3, rand_vec());
    exp7 = alu_res(OP_ADD, ref_rf[2], ref_rf[3]);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_srca  = 3'd2;
    bus.cmd_srcb  = 3'd3;
    bus.cmd_dst   = 3'd7;
    accepted = 0;
    for (int c = 0; c < 12; c++) begin
      host_wr_en = (c >= 1 && c <= 3);
      host_addr  = 3'd5;
      host_wdata = mk(0, 0, 16'hAAAA);
      #1;
      if (bus.cmd_valid && bus.cmd_ready) accepted++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    host_wr_en = 1'b0;
    ref_rf[7] = exp7;
    ref_flags = alu_flg(OP_ADD, ref_rf[2], ref_rf[3]);
    ref_count = ref_count + 16'd3;
    exp_done += 3;
    n_tests++;
    if (accepted != 3) begin
      n_fail++;
      $display("FAIL busy_accepts: %0d accepted in 12 cycles, required 3", accepted);
    end
    read_reg(5, d);
    n_tests++;
    if (d !== ref_rf[5]) begin
      n_fail++;
      $display("FAIL busy_host_write: r5=%h, required %h", d, ref_rf[5]);
    end
    read_reg(7, d);
    n_tests++;
    if (d !== exp7 || op_count !== ref_count || done_cnt !== exp_done) begin
      n_fail++;
      $display("FAIL busy_result: r7=%h cnt=%h dones=%0d, required %h %h %0d", d, op_count,
               done_cnt, exp7, ref_count, exp_done);
    end
  endtask

  task automatic test_random();
    vec_t       d;
    logic [3:0] op;
    int         a, b, dst;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) host_write(int'($urandom_range(0, 7)), rand_vec());
      op  = 4'($urandom_range(0, 15));
      a   = int'($urandom_range(0, 7));
      b   = int'($urandom_range(0, 7));
      dst = int'($urandom_range(0, 7));
      run_cmd(op, a, b, dst);
      read_reg(dst, d);
      n_tests++;
      if (d !== ref_rf[dst] || flags_q !== ref_flags || op_count !== ref_count ||
          bus.alu_op !== op) begin
        n_fail++;
        $display("FAIL random%0d op=%h: r%0d=%h flags=%h cnt=%h aop=%h, required %h %h %h %h",
                 it, op, dst, d, flags_q, op_count, bus.alu_op, ref_rf[dst], ref_flags,
                 ref_count, op);
      end
    end
    for (int i = 0; i < R; i++) begin
      read_reg(i, d);
      n_tests++;
      if (d !== ref_rf[i]) begin
        n_fail++;
        $display("FAIL final_reg%0d: got %h, required %h", i, d, ref_rf[i]);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t d;
    host_write(2, rand_vec());
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    ref_count = 16'hFFFF;
    run_cmd(OP_SUB, 2, 2, 6);
    read_reg(6, d);
    n_tests++;
    if (op_count !== 16'd0 || d !== '0 || flags_q[FLG_Z] !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_zero: cnt=%h r6=%h z=%b, required 0 0 1", op_count, d,
               flags_q[FLG_Z]);
    end
  endtask

  initial begin
    host_wr_en    = 1'b0;
    host_addr     = '0;
    host_wdata    = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_srca  = '0;
    bus.cmd_srcb  = '0;
    bus.cmd_dst   = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_host_rw();
    test_add();
    test_rsum();
    test_back_to_back();
    test_busy();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
